// File: rtl/rco_capture_pkg.sv
// Shared constants for the rco capture block: entry layout and drop counter limits.
package rco_capture_pkg;

    localparam int unsigned SEQ_W    = 2;
    localparam int unsigned MODO_W   = 2;
    localparam int unsigned TAG_W    = SEQ_W + MODO_W;
    localparam int unsigned DROP_W   = 4;
    localparam logic [DROP_W-1:0] DROP_MAX = 4'd15;

    // Entry layout, LSB first: Q, then modo, then seq.
    localparam int unsigned Q_OFF = 0;

    function automatic int unsigned entry_w(input int unsigned qw);
        return qw + TAG_W;
    endfunction

    function automatic int unsigned modo_off(input int unsigned qw);
        return qw;
    endfunction

    function automatic int unsigned seq_off(input int unsigned qw);
        return qw + MODO_W;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO holding captured entries; head is presented combinationally, zero when empty.
module capture_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == FULL_LVL);
    assign level   = level_q;
    assign pop_ok  = pop && !empty;
    // A pop frees the slot this cycle, so a push into a full FIFO is fine when paired with a pop.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointer and level values; flush wins over any push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents are only observable through level, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/rco_capture.sv
// Captures {seq, modo, Q} on each rising edge of rco into a small FIFO, tracking drops.
module rco_capture
    import rco_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned QW    = 4
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic [QW-1:0]              Q,
    input  logic                       rco,
    input  logic [1:0]                 modo,
    input  logic                       capture_en,
    input  logic                       clear,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [QW+3:0]              out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [3:0]                 drop_cnt
);

    localparam int unsigned EW      = entry_w(QW);
    localparam int unsigned MODO_LO = modo_off(QW);
    localparam int unsigned SEQ_LO  = seq_off(QW);

    logic              rco_q;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              rco_event;
    logic              cap_event;
    logic              pop;
    logic              accept;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EW-1:0]     wdata;

    assign rco_event = rco && !rco_q;
    assign cap_event = rco_event && capture_en && !clear;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign accept    = cap_event && (!fifo_full || pop);
    assign drop      = cap_event && fifo_full && !pop;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    // Assemble the entry from the current-cycle sample.
    always_comb begin
        wdata = '0;
        wdata[Q_OFF   +: QW]     = Q;
        wdata[MODO_LO +: MODO_W] = modo;
        wdata[SEQ_LO  +: SEQ_W]  = seq_q;
    end

    // Previous rco; resets high so an rco already high at release is not an edge.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) rco_q <= 1'b1;
        else          rco_q <= rco;
    end

    // Sequence tag, sticky overflow and saturating drop counter next state.
    always_comb begin
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            seq_d      = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (accept) seq_d = seq_q + 1'b1;
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    capture_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .reset_L (reset_L),
        .flush   (clear),
        .push    (cap_event),
        .pop     (pop),
        .wdata   (wdata),
        .rdata   (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

endmodule

// File: tb/tb_rco_capture.sv
// Directed bench for rco_capture with hand-computed expected entries.
module tb_rco_capture;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [3:0] Q;
    logic       rco;
    logic [1:0] modo;
    logic       capture_en;
    logic       clear;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       overflow;
    logic [3:0] drop_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;

    rco_capture #(
        .DEPTH (4),
        .QW    (4)
    ) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .Q          (Q),
        .rco        (rco),
        .modo       (modo),
        .capture_en (capture_en),
        .clear      (clear),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .level      (level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle rco pulse; the entry (if accepted) is visible after the first step.
    task automatic ev(input logic [3:0] q, input logic [1:0] m);
        Q    = q;
        modo = m;
        rco  = 1'b1;
        step();
        rco  = 1'b0;
        step();
    endtask

    initial begin
        reset_L = 1'b0; Q = '0; rco = 1'b1; modo = '0;
        capture_en = 1'b1; clear = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_cnt), 0);

        // rco already high at release, held for 5 cycles: no event
        reset_L = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("hold_level", 32'(level), 0);
        chk("hold_valid", 32'(out_valid), 0);
        rco = 1'b0;
        step();

        // three events, out_ready low
        for (int i = 0; i < 3; i++) ev(4'hF, 2'b01);
        chk("three_level", 32'(level), 3);
        chk("head0", 32'(out_data), 32'h1F);
        out_ready = 1'b1;
        step();
        chk("head1", 32'(out_data), 32'h5F);
        step();
        chk("head2", 32'(out_data), 32'h9F);
        step();
        out_ready = 1'b0;
        chk("drain_level", 32'(level), 0);
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_data", 32'(out_data), 0);

        // clear to restart seq at 0
        clear = 1'b1;
        step();
        clear = 1'b0;

        // six events into depth 4
        for (int i = 0; i < 6; i++) ev(4'h2, 2'b10);
        chk("full_level", 32'(level), 4);
        chk("full_ovf", 32'(overflow), 1);
        chk("full_drop", 32'(drop_cnt), 2);
        chk("full_head", 32'(out_data), 32'h22);

        // full + simultaneous pop and event: push accepted, seq wrapped to 0
        Q = 4'h5; modo = 2'b11; rco = 1'b1; out_ready = 1'b1;
        chk("fpop_oldest", 32'(out_data), 32'h22);
        step();
        rco = 1'b0; out_ready = 1'b0;
        chk("fpop_level", 32'(level), 4);
        chk("fpop_drop", 32'(drop_cnt), 2);
        chk("fpop_head", 32'(out_data), 32'h62);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_head", 32'(out_data), 32'hA2);
        chk("pop_level", 32'(level), 3);

        // capture disabled: nothing stored or dropped
        capture_en = 1'b0;
        ev(4'h9, 2'b00);
        ev(4'h9, 2'b00);
        chk("dis_level", 32'(level), 3);
        chk("dis_drop", 32'(drop_cnt), 2);
        capture_en = 1'b1;

        // mid-level push and pop together: level unchanged, order kept
        Q = 4'h1; modo = 2'b00; rco = 1'b1; out_ready = 1'b1;
        step();
        rco = 1'b0; out_ready = 1'b0;
        chk("pp_level", 32'(level), 3);
        chk("pp_head", 32'(out_data), 32'hE2);
        step();

        // clear with level 3 and overflow set; coincident event discarded
        clear = 1'b1; rco = 1'b1; Q = 4'hC;
        step();
        clear = 1'b0; rco = 1'b0;
        chk("clr_level", 32'(level), 0);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_drop", 32'(drop_cnt), 0);
        step();
        chk("clr_still_empty", 32'(level), 0);
        ev(4'h7, 2'b00);
        chk("clr_seq0", 32'(out_data), 32'h07);

        // reset mid-stream with level 2
        ev(4'h8, 2'b00);
        chk("pre_rst_level", 32'(level), 2);
        reset_L = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        step();
        reset_L = 1'b1;
        step();
        chk("post_rst_level", 32'(level), 0);
        ev(4'h3, 2'b01);
        chk("post_rst_seq0", 32'(out_data), 32'h13);

        // drop counter saturation
        for (int i = 0; i < 3; i++) ev(4'h4, 2'b00);
        for (int i = 0; i < 16; i++) ev(4'h4, 2'b00);
        chk("sat_level", 32'(level), 4);
        chk("sat_drop", 32'(drop_cnt), 15);
        chk("sat_ovf", 32'(overflow), 1);
        chk("sat_head", 32'(out_data), 32'h13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rco_capture.md
RCO_CAPTURE -- requirements
Module: rco_capture

Interface
REQ-001 Parameter DEPTH, default 4, number of FIFO entries; power of two, 2..16.
REQ-002 Parameter QW, default 4, width of the counter value Q.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_L  input  1  asynchronous active-low reset; deasserts synchronously to clk.
REQ-005 Q  input  QW  counter value from the upstream 4-bit mode counter.
REQ-006 rco  input  1  ripple-carry-out from the upstream counter.
REQ-007 modo  input  2  counter mode currently driven to the upstream counter; captured as a tag.
REQ-008 capture_en  input  1  when 0, rco events are ignored (not captured, not counted as drops).
REQ-009 clear  input  1  synchronous flush.
REQ-010 out_ready  input  1  downstream consumer accepts the head entry.
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 out_data  output  QW+4  head entry {seq[1:0], modo[1:0], Q[QW-1:0]}; all zeros when empty.
REQ-013 level  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-014 overflow  output  1  sticky; set on the first dropped event.
REQ-015 drop_cnt  output  4  dropped-event count, saturating at 15.

Function
REQ-016 An event SHALL be the rising edge of rco: rco==1 in the current cycle and rco_q==0, where rco_q is rco registered one cycle.
REQ-017 On an event with capture_en==1, the block SHALL push {seq, modo, Q} sampled in that same cycle; the entry is visible on out_data/out_valid in the next cycle (latency 1).
REQ-018 seq SHALL be a 2-bit counter that increments by 1 on every accepted push and wraps from 3 to 0; dropped events do not increment it.
REQ-019 A pop SHALL occur in any cycle with out_valid==1 and out_ready==1; out_ready while empty has no effect.
REQ-020 When the FIFO is full, an event with no simultaneous pop SHALL be dropped, overflow set to 1, and drop_cnt incremented (holding at 15).
REQ-021 When the FIFO is full and a pop and an event occur in the same cycle, the push SHALL be accepted; level stays at DEPTH.
REQ-022 When the FIFO is empty and an event occurs, level SHALL become 1 on the next cycle; no bypass to out_data in the same cycle.
REQ-023 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and preserve FIFO order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 clear==1 SHALL, on the next edge, empty the FIFO, zero seq, overflow, and drop_cnt, and discard any event in that cycle; rco_q keeps tracking rco.
REQ-026 rco held high for several cycles SHALL produce exactly one event.

Reset
REQ-027 While reset_L==0: level=0, out_valid=0, out_data=0, overflow=0, drop_cnt=0, seq=0, pointers=0.
REQ-028 rco_q SHALL reset to 1, so an rco already high at reset release produces no event.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries immediately, with no pop or push completing in that cycle.

Structure
REQ-030 The shared package SHALL hold the entry-width constant (QW+4), the field offsets for seq/modo/Q, and the drop_cnt saturation value.
REQ-031 Storage SHALL be a separate sub-module capture_fifo: synchronous FIFO with push, pop, full, empty, and level.
REQ-032 Edge detect, seq counter, drop/overflow logic, and clear SHALL reside in rco_capture.

Verification
REQ-033 Reset release with rco=1, then rco held high for 5 cycles -> level stays 0, out_valid=0.
REQ-034 Three events with Q=4'hF, modo=2'b01, out_ready=0 -> out_data head = 8'h1F then 8'h5F, 8'h9F in order; level=3.
REQ-035 Six events, DEPTH=4, out_ready=0 -> level=4, overflow=1, drop_cnt=2; the fourth entry has seq=3.
REQ-036 FIFO full, event coinciding with out_ready=1 -> the pop returns the oldest entry, the new entry is appended, level=4, drop_cnt unchanged.
REQ-037 Events with capture_en=0 -> level and drop_cnt unchanged; clear pulsed while level=3 and overflow=1 -> next cycle level=0, overflow=0, drop_cnt=0, seq restarts at 0.
REQ-038 reset_L pulsed low mid-stream with level=2 -> out_valid=0 immediately; after release, the first capture has seq=0.
